// File: rtl/timer_mc_top_if.sv
// rtl/timer_mc_top_if.sv - APB register bus between the CPU bridge and the multi-channel timer
interface timer_mc_top_if;
    logic        tim_psel;
    logic        tim_pwrite;
    logic        tim_penable;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic [31:0] tim_prdata;
    logic        tim_pready;
    logic        tim_pslverr;

    modport master (
        output tim_psel, tim_pwrite, tim_penable, tim_paddr, tim_pwdata, tim_pstrb,
        input  tim_prdata, tim_pready, tim_pslverr
    );

    modport slave (
        input  tim_psel, tim_pwrite, tim_penable, tim_paddr, tim_pwdata, tim_pstrb,
        output tim_prdata, tim_pready, tim_pslverr
    );
endinterface

// File: rtl/timer_mc_top.sv
// rtl/timer_mc_top.sv - shared prescaled up-counter with NUM_CH compare channels and interrupts
module timer_mc_top #(
    parameter int CNT_WIDTH = 64,
    parameter int NUM_CH    = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    timer_mc_top_if.slave     apb,
    input  logic              dbg_mode,
    output logic              tim_int,
    output logic [NUM_CH-1:0] tim_int_ch
);

    localparam bit HAS_HI = (CNT_WIDTH == 64);

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] strb);
        logic [31:0] v;
        for (int b = 0; b < 4; b++) v[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return v;
    endfunction

    function automatic logic [63:0] f_merge64(input logic [63:0] old, input logic hi,
                                              input logic [31:0] wd, input logic [3:0] strb);
        logic [63:0] v;
        v = old;
        if (hi) v[63:32] = f_merge(old[63:32], wd, strb);
        else    v[31:0]  = f_merge(old[31:0], wd, strb);
        return v;
    endfunction

    logic                 r_timer_en, r_div_en, r_arm, r_en_d, r_halt_req;
    logic [3:0]           r_div_val;
    logic [7:0]           r_div;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_cmp [NUM_CH];
    logic [NUM_CH-1:0]    r_tier, r_tisr;

    logic [9:0]           w_waddr;
    logic [4:0]           w_cmp_idx;
    logic                 w_access, w_wr, w_cmp_hi, w_cmp_hit;
    logic                 w_sel_tcr, w_sel_tdr0, w_sel_tdr1, w_sel_thcsr, w_sel_tier, w_sel_tisr;
    logic [31:0]          w_tcr_cur, w_tcr_new, w_rdata;
    logic                 w_tcr_err, w_halt_ack, w_run, w_tick, w_cnt_en, w_clr;
    logic [7:0]           w_div_max;
    logic [63:0]          w_cnt64;
    logic [63:0]          w_cmp64 [NUM_CH];
    logic [NUM_CH-1:0]    w_match, w_w1c;
    logic                 w_unused;

    assign w_access    = apb.tim_psel & apb.tim_penable;
    assign w_wr        = w_access & apb.tim_pwrite;
    assign w_waddr     = apb.tim_paddr[11:2];
    assign w_sel_tcr   = (w_waddr == 10'h000);
    assign w_sel_tdr0  = (w_waddr == 10'h001);
    assign w_sel_tdr1  = (w_waddr == 10'h002);
    assign w_sel_thcsr = (w_waddr == 10'h003);
    assign w_sel_tier  = (w_waddr == 10'h004);
    assign w_sel_tisr  = (w_waddr == 10'h005);
    assign w_cmp_idx   = apb.tim_paddr[7:3];
    assign w_cmp_hi    = apb.tim_paddr[2];
    assign w_cmp_hit   = (apb.tim_paddr[11:8] == 4'h1) && (int'(w_cmp_idx) < NUM_CH);

    // A rejected TCR write leaves every field untouched, including timer_en.
    assign w_tcr_cur = {20'd0, r_div_val, 5'd0, r_arm, r_div_en, r_timer_en};
    assign w_tcr_new = f_merge(w_tcr_cur, apb.tim_pwdata, apb.tim_pstrb);
    assign w_tcr_err = (w_tcr_new[11:8] > 4'd8) ||
                       (r_timer_en && ((w_tcr_new[1] != r_div_en) || (w_tcr_new[11:8] != r_div_val)));

    assign w_halt_ack = dbg_mode & r_halt_req;
    assign w_run      = r_timer_en & ~w_halt_ack;
    assign w_div_max  = 8'((9'd1 << r_div_val) - 9'd1);
    assign w_tick     = ~r_div_en | (r_div >= w_div_max);
    assign w_cnt_en   = w_run & w_tick;
    assign w_clr      = r_en_d & ~r_timer_en;
    assign w_cnt64    = 64'(r_cnt);
    assign w_w1c      = (w_wr && w_sel_tisr && apb.tim_pstrb[0]) ? apb.tim_pwdata[NUM_CH-1:0] : '0;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_cmp64[i] = 64'(r_cmp[i]);
            w_match[i] = (r_cmp[i] == r_cnt);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel_tcr)        w_rdata = w_tcr_cur;
        else if (w_sel_tdr0)  w_rdata = w_cnt64[31:0];
        else if (w_sel_tdr1)  w_rdata = w_cnt64[63:32];
        else if (w_sel_thcsr) w_rdata = {30'd0, w_halt_ack, r_halt_req};
        else if (w_sel_tier)  w_rdata = 32'(r_tier);
        else if (w_sel_tisr)  w_rdata = 32'(r_tisr);
        else if (w_cmp_hit) begin
            for (int i = 0; i < NUM_CH; i++)
                if (w_cmp_idx == 5'(i)) w_rdata = w_cmp_hi ? w_cmp64[i][63:32] : w_cmp64[i][31:0];
        end
    end

    assign apb.tim_prdata  = w_access ? w_rdata : 32'd0;
    assign apb.tim_pready  = w_access;
    assign apb.tim_pslverr = w_wr & w_sel_tcr & w_tcr_err;
    assign tim_int_ch      = r_tisr & r_tier;
    assign tim_int         = |tim_int_ch;
    assign w_unused        = ^{apb.tim_paddr[1:0], w_tcr_new[31:12], w_tcr_new[7:3]};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_timer_en <= 1'b0;
            r_div_en   <= 1'b0;
            r_arm      <= 1'b0;
            r_div_val  <= '0;
            r_en_d     <= 1'b0;
            r_halt_req <= 1'b0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_tier     <= '0;
            r_tisr     <= '0;
            for (int i = 0; i < NUM_CH; i++) r_cmp[i] <= '1;
        end else begin
            r_en_d <= r_timer_en;
            if (w_wr && w_sel_tcr && !w_tcr_err) begin
                r_timer_en <= w_tcr_new[0];
                r_div_en   <= w_tcr_new[1];
                r_arm      <= w_tcr_new[2];
                r_div_val  <= w_tcr_new[11:8];
            end
            if (w_wr && w_sel_thcsr && apb.tim_pstrb[0]) r_halt_req <= apb.tim_pwdata[0];
            if (w_wr && w_sel_tier && apb.tim_pstrb[0])  r_tier <= apb.tim_pwdata[NUM_CH-1:0];
            // Match is OR'd after the clear so a persisting match always wins over W1C.
            r_tisr <= (r_tisr & ~w_w1c) | w_match;

            if (w_clr)                    r_div <= '0;
            else if (w_run && r_div_en)   r_div <= (r_div >= w_div_max) ? 8'd0 : r_div + 8'd1;

            if (w_wr && w_sel_tdr0)
                r_cnt <= CNT_WIDTH'(f_merge64(w_cnt64, 1'b0, apb.tim_pwdata, apb.tim_pstrb));
            else if (w_wr && w_sel_tdr1 && HAS_HI)
                r_cnt <= CNT_WIDTH'(f_merge64(w_cnt64, 1'b1, apb.tim_pwdata, apb.tim_pstrb));
            else if (w_clr)
                r_cnt <= '0;
            else if (r_arm && w_cnt_en && w_match[0])
                r_cnt <= '0;
            else if (w_cnt_en)
                r_cnt <= r_cnt + CNT_WIDTH'(1);

            for (int i = 0; i < NUM_CH; i++)
                if (w_wr && w_cmp_hit && (w_cmp_idx == 5'(i)) && (!w_cmp_hi || HAS_HI))
                    r_cmp[i] <= CNT_WIDTH'(f_merge64(w_cmp64[i], w_cmp_hi, apb.tim_pwdata, apb.tim_pstrb));
        end
    end

endmodule

// File: tb/tb_timer_mc_top.sv
// tb/tb_timer_mc_top.sv - self-checking bench for timer_mc_top (64-bit/4-ch and 32-bit/1-ch builds)
module tb_timer_mc_top;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        dbg_mode = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, tsel = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        tim_int, tim_int32;
    logic [3:0]  tim_int_ch;
    logic [0:0]  tim_int_ch32;
    logic        last_err;
    int          checks = 0;
    int          errors = 0;

    timer_mc_top_if bus ();
    timer_mc_top_if bus32 ();

    assign bus.tim_psel      = psel & ~tsel;
    assign bus32.tim_psel    = psel & tsel;
    assign bus.tim_penable   = penable;
    assign bus32.tim_penable = penable;
    assign bus.tim_pwrite    = pwrite;
    assign bus32.tim_pwrite  = pwrite;
    assign bus.tim_paddr     = paddr;
    assign bus32.tim_paddr   = paddr;
    assign bus.tim_pwdata    = pwdata;
    assign bus32.tim_pwdata  = pwdata;
    assign bus.tim_pstrb     = pstrb;
    assign bus32.tim_pstrb   = pstrb;

    timer_mc_top #(.CNT_WIDTH(64), .NUM_CH(4)) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .apb(bus), .dbg_mode(dbg_mode),
        .tim_int(tim_int), .tim_int_ch(tim_int_ch));

    timer_mc_top #(.CNT_WIDTH(32), .NUM_CH(1)) u_dut32 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .apb(bus32), .dbg_mode(dbg_mode),
        .tim_int(tim_int32), .tim_int_ch(tim_int_ch32));

    always #5 sys_clk = ~sys_clk;

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d; pstrb = s;
        @(posedge sys_clk); #1 penable = 1'b1;
        #1 last_err = tsel ? bus32.tim_pslverr : bus.tim_pslverr;
        @(posedge sys_clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(posedge sys_clk); #1 penable = 1'b1;
        #1 d = tsel ? bus32.tim_prdata : bus.tim_prdata;
        e = tsel ? bus32.tim_pslverr : bus.tim_pslverr;
        @(posedge sys_clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge sys_clk);
        #1 apb_wr(12'h014, 32'hF, 4'hF);
    endtask

    task automatic test_reset();
        logic [31:0] d, exp; logic e; logic [11:0] a;
        checks++; if (tim_int !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", tim_int); end
        checks++; if (tim_int_ch !== 4'h0) begin errors++; $display("FAIL reset_int_ch got %h exp 0", tim_int_ch); end
        for (int i = 0; i < 14; i++) begin
            a   = (i < 6) ? 12'(i * 4) : 12'(256 + (i - 6) * 4);
            exp = (i < 6) ? 32'h0 : 32'hFFFF_FFFF;
            apb_rd(a, d, e);
            checks++; if (d !== exp) begin errors++; $display("FAIL reset_read %h got %h exp %h", a, d, exp); end
            checks++; if (e !== 1'b0) begin errors++; $display("FAIL reset_slverr %h got %b exp 0", a, e); end
        end
    endtask

    task automatic test_regs_random();
        logic [31:0] m_cmp [8];
        logic [3:0]  m_tier;
        logic        m_halt;
        logic [31:0] d, rd, exp; logic [3:0] s; logic e; logic [11:0] a; int r;
        for (int i = 0; i < 8; i++) m_cmp[i] = 32'hFFFF_FFFF;
        m_tier = '0; m_halt = 1'b0;
        repeat (24) begin
            r = $urandom_range(0, 9); d = $urandom; s = 4'($urandom_range(0, 15));
            a = (r < 8) ? 12'(256 + r * 4) : ((r == 8) ? 12'h010 : 12'h00C);
            apb_wr(a, d, s);
            checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL rand_wr_slverr %h got %b exp 0", a, last_err); end
            if (r < 8) begin
                for (int b = 0; b < 4; b++) if (s[b]) m_cmp[r][8*b +: 8] = d[8*b +: 8];
            end else if (s[0]) begin
                if (r == 8) m_tier = d[3:0]; else m_halt = d[0];
            end
            exp = (r < 8) ? m_cmp[r] : ((r == 8) ? {28'd0, m_tier} : {31'd0, m_halt});
            apb_rd(a, rd, e);
            checks++; if (rd !== exp) begin errors++; $display("FAIL rand_rd %h got %h exp %h", a, rd, exp); end
        end
        apb_wr(12'h018, $urandom, 4'hF);
        checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL unmapped_slverr got %b exp 0", last_err); end
        apb_rd(12'h018, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_rd got %h exp 0", rd); end
        apb_rd(12'h120, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cmp4_rd got %h exp 0", rd); end
        for (int i = 0; i < 8; i++) apb_wr(12'(256 + i * 4), 32'hFFFF_FFFF, 4'hF);
        apb_wr(12'h010, 32'h0, 4'hF);
        apb_wr(12'h00C, 32'h0, 4'hF);
        apb_wr(12'h014, 32'hF, 4'hF);
    endtask

    task automatic test_counting();
        logic [63:0] st, ev; logic [31:0] rd, tcr; logic e; int j, k, dv, den, eff;
        repeat (5) begin
            st = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) st[31:0] = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            dv = $urandom_range(0, 4); den = $urandom_range(0, 1); j = $urandom_range(0, 30);
            eff = (den == 1) ? dv : 0;
            tcr = 32'h1 | (32'(den) << 1) | (32'(dv) << 8);
            apb_wr(12'h004, st[31:0], 4'hF);
            apb_wr(12'h008, st[63:32], 4'hF);
            apb_wr(12'h000, tcr, 4'hF);
            checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL cnt_tcr_slverr got %b exp 0", last_err); end
            repeat (j) @(posedge sys_clk);
            #1;
            k = j + 1;
            ev = st + 64'(k >> eff);
            apb_rd(12'h004, rd, e);
            checks++; if (rd !== ev[31:0]) begin errors++; $display("FAIL cnt_lo got %h exp %h", rd, ev[31:0]); end
            ev = st + 64'((k + 2) >> eff);
            apb_rd(12'h008, rd, e);
            checks++; if (rd !== ev[63:32]) begin errors++; $display("FAIL cnt_hi got %h exp %h", rd, ev[63:32]); end
            apb_wr(12'h000, tcr & ~32'h1, 4'hF);
            checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL cnt_dis_slverr got %b exp 0", last_err); end
            repeat (2) @(posedge sys_clk);
            #1 apb_rd(12'h004, rd, e);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cnt_clear got %h exp 0", rd); end
            apb_wr(12'h000, 32'h0, 4'hF);
        end
        settle();
    endtask

    task automatic test_compare();
        logic [31:0] rd; logic e;
        apb_wr(12'h108, 32'd5, 4'hF);
        apb_wr(12'h10C, 32'd0, 4'hF);
        apb_wr(12'h010, 32'h2, 4'hF);
        apb_wr(12'h000, 32'h1, 4'hF);
        repeat (5) @(posedge sys_clk);
        #1;
        checks++; if (tim_int !== 1'b0) begin errors++; $display("FAIL cmp_int_early got %b exp 0", tim_int); end
        @(posedge sys_clk); #1;
        checks++; if (tim_int !== 1'b1) begin errors++; $display("FAIL cmp_int got %b exp 1", tim_int); end
        checks++; if (tim_int_ch !== 4'b0010) begin errors++; $display("FAIL cmp_int_ch got %b exp 0010", tim_int_ch); end
        apb_wr(12'h000, 32'h0, 4'hF);
        apb_wr(12'h014, 32'h2, 4'h1);
        apb_rd(12'h014, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_tisr got %h exp 0", rd); end
        checks++; if (tim_int !== 1'b0) begin errors++; $display("FAIL w1c_int got %b exp 0", tim_int); end
        apb_wr(12'h004, 32'd5, 4'hF);
        apb_wr(12'h014, 32'h2, 4'h1);
        apb_rd(12'h014, rd, e);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL held_match_tisr got %h exp 2", rd); end
        checks++; if (tim_int !== 1'b1) begin errors++; $display("FAIL held_match_int got %b exp 1", tim_int); end
        apb_wr(12'h010, 32'h0, 4'hF);
        checks++; if (tim_int !== 1'b0) begin errors++; $display("FAIL tier_off_int got %b exp 0", tim_int); end
        apb_rd(12'h014, rd, e);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL tier_keeps_tisr got %h exp 2", rd); end
        apb_wr(12'h004, 32'd0, 4'hF);
        apb_wr(12'h108, 32'hFFFF_FFFF, 4'hF);
        apb_wr(12'h10C, 32'hFFFF_FFFF, 4'hF);
        settle();
    endtask

    task automatic test_prescaler();
        logic [31:0] rd; logic e;
        apb_wr(12'h000, 32'h303, 4'hF);
        repeat (15) @(posedge sys_clk);
        #1 apb_rd(12'h004, rd, e);
        checks++; if (rd !== 32'd2) begin errors++; $display("FAIL presc_cnt got %0d exp 2", rd); end
        apb_wr(12'h000, 32'h403, 4'hF);
        checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL divval_run_slverr got %b exp 1", last_err); end
        apb_wr(12'h000, 32'h301, 4'hF);
        checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL diven_run_slverr got %b exp 1", last_err); end
        apb_rd(12'h000, rd, e);
        checks++; if (rd !== 32'h303) begin errors++; $display("FAIL tcr_kept got %h exp 303", rd); end
        apb_wr(12'h000, 32'h302, 4'hF);
        checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL disable_slverr got %b exp 0", last_err); end
        apb_wr(12'h000, 32'h900, 4'hF);
        checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL div9_slverr got %b exp 1", last_err); end
        apb_rd(12'h000, rd, e);
        checks++; if (rd !== 32'h302) begin errors++; $display("FAIL div9_tcr got %h exp 302", rd); end
        apb_wr(12'h000, 32'h800, 4'hF);
        checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL div8_slverr got %b exp 0", last_err); end
        apb_wr(12'h000, 32'h0, 4'hF);
        settle();
    endtask

    task automatic test_autoreload();
        logic [31:0] rd; logic e; int t, j;
        apb_wr(12'h100, 32'd3, 4'hF);
        apb_wr(12'h104, 32'd0, 4'hF);
        apb_wr(12'h014, 32'hF, 4'hF);
        apb_wr(12'h000, 32'h5, 4'hF);
        t = 0;
        repeat (4) begin
            j = $urandom_range(0, 9);
            repeat (j) @(posedge sys_clk);
            #1 t += j;
            apb_rd(12'h004, rd, e);
            checks++; if (rd !== 32'((t + 1) % 4)) begin errors++; $display("FAIL reload_cnt got %0d exp %0d", rd, (t + 1) % 4); end
            t += 2;
        end
        apb_wr(12'h014, 32'h1, 4'h1);
        repeat (5) @(posedge sys_clk);
        #1 apb_rd(12'h014, rd, e);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reload_tisr got %h exp 1", rd); end
        apb_wr(12'h000, 32'h0, 4'hF);
        apb_wr(12'h100, 32'hFFFF_FFFF, 4'hF);
        apb_wr(12'h104, 32'hFFFF_FFFF, 4'hF);
        settle();
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic e;
        apb_wr(12'h004, 32'hFFFF_FFFF, 4'hF);
        apb_wr(12'h008, 32'hFFFF_FFFF, 4'hF);
        apb_wr(12'h000, 32'h1, 4'hF);
        apb_rd(12'h004, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrap_lo got %h exp 0", rd); end
        apb_rd(12'h008, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrap_hi got %h exp 0", rd); end
        apb_rd(12'h014, rd, e);
        checks++; if (rd !== 32'hF) begin errors++; $display("FAIL wrap_tisr got %h exp f", rd); end
        apb_wr(12'h000, 32'h0, 4'hF);
        settle();
    endtask

    task automatic test_halt();
        logic [31:0] rd; logic e; int m;
        m = $urandom_range(3, 20);
        apb_wr(12'h00C, 32'h1, 4'hF);
        apb_wr(12'h000, 32'h1, 4'hF);
        repeat (m) @(posedge sys_clk);
        #1 dbg_mode = 1'b1;
        apb_rd(12'h004, rd, e);
        checks++; if (rd !== 32'(m)) begin errors++; $display("FAIL halt_cnt got %0d exp %0d", rd, m); end
        apb_rd(12'h00C, rd, e);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL halt_ack got %h exp 3", rd); end
        repeat (7) @(posedge sys_clk);
        #1 apb_rd(12'h004, rd, e);
        checks++; if (rd !== 32'(m)) begin errors++; $display("FAIL halt_frozen got %0d exp %0d", rd, m); end
        dbg_mode = 1'b0;
        apb_rd(12'h004, rd, e);
        checks++; if (rd !== 32'(m + 1)) begin errors++; $display("FAIL resume1 got %0d exp %0d", rd, m + 1); end
        apb_rd(12'h004, rd, e);
        checks++; if (rd !== 32'(m + 3)) begin errors++; $display("FAIL resume2 got %0d exp %0d", rd, m + 3); end
        apb_wr(12'h000, 32'h0, 4'hF);
        apb_wr(12'h00C, 32'h0, 4'hF);
        settle();
    endtask

    task automatic test_dut32();
        logic [31:0] rd, d; logic e;
        tsel = 1'b1;
        apb_wr(12'h008, 32'hA5A5_A5A5, 4'hF);
        apb_rd(12'h008, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w32_tdr1 got %h exp 0", rd); end
        apb_rd(12'h108, rd, e);
        checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL w32_cmp1 got %h/%b exp 0/0", rd, e); end
        apb_rd(12'h100, rd, e);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL w32_cmp0lo got %h exp ffffffff", rd); end
        apb_rd(12'h104, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w32_cmp0hi got %h exp 0", rd); end
        d = $urandom;
        apb_wr(12'h004, d, 4'hF);
        apb_rd(12'h004, rd, e);
        checks++; if (rd !== d) begin errors++; $display("FAIL w32_tdr0 got %h exp %h", rd, d); end
        checks++; if (tim_int32 !== 1'b0 || tim_int_ch32 !== 1'b0) begin errors++; $display("FAIL w32_int got %b exp 0", tim_int32); end
        tsel = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; logic e;
        apb_wr(12'h100, 32'd2, 4'hF);
        apb_wr(12'h104, 32'd0, 4'hF);
        apb_wr(12'h010, 32'h1, 4'hF);
        apb_wr(12'h000, 32'h1, 4'hF);
        repeat (5) @(posedge sys_clk);
        #1;
        checks++; if (tim_int !== 1'b1) begin errors++; $display("FAIL pre_rst_int got %b exp 1", tim_int); end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++; if (tim_int !== 1'b0 || tim_int_ch !== 4'h0) begin errors++; $display("FAIL rst_int got %b exp 0", tim_int); end
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        apb_rd(12'h000, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_tcr got %h exp 0", rd); end
        apb_rd(12'h100, rd, e);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp0 got %h exp ffffffff", rd); end
        apb_rd(12'h004, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_cnt got %h exp 0", rd); end
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        test_reset();
        test_regs_random();
        test_counting();
        test_compare();
        test_prescaler();
        test_autoreload();
        test_wrap();
        test_halt();
        test_dut32();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
